// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared sizes, accumulator width, FSM states and Q8.8 limits for the window MAC
package cnn_pkg;

    localparam int ROW         = 28;
    localparam int K           = 5;
    localparam int DATA_WIDTH  = 16;
    localparam int WEIGHT_SIZE = 25;
    localparam int ADDRESS_NUM = 5;
    localparam int LANES       = 5;
    localparam int FRAC_BITS   = 8;
    localparam int IDX_WIDTH   = 10;

    // Wide enough that weight_size full-width products can never overflow.
    function automatic int acc_width(input int dw, input int ws);
        return 2 * dw + $clog2(ws) + 1;
    endfunction

    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, WEIGHT_SIZE);
    localparam int FMAP_SIZE = (ROW - K + 1) * (ROW - K + 1);

    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = 16'sh7fff;
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        POST,
        HOLD
    } state_t;

endpackage

// File: rtl/win_postproc.sv
// rtl/win_postproc.sv - bias add, round-half-up, Q8.8 saturation and optional ReLU
module win_postproc
    import cnn_pkg::*;
(
    input  logic signed [ACC_WIDTH-1:0]  acc,
    input  logic signed [DATA_WIDTH-1:0] bias,
    input  logic                         relu_en,
    output logic signed [DATA_WIDTH-1:0] result
);

    // Two guard bits so the bias and rounding terms cannot wrap the sum.
    localparam int SUM_WIDTH = ACC_WIDTH + 2;

    logic signed [SUM_WIDTH-1:0] sum;
    logic signed [SUM_WIDTH-1:0] scaled;

    always_comb begin
        sum    = SUM_WIDTH'(acc)
               + (SUM_WIDTH'(bias) <<< FRAC_BITS)
               + (SUM_WIDTH'(1) <<< (FRAC_BITS - 1));
        scaled = sum >>> FRAC_BITS;
        if (scaled > SUM_WIDTH'(SAT_MAX)) begin
            result = SAT_MAX;
        end else if (scaled < SUM_WIDTH'(SAT_MIN)) begin
            result = SAT_MIN;
        end else begin
            result = scaled[DATA_WIDTH-1:0];
        end
        if (relu_en && result[DATA_WIDTH-1]) begin
            result = '0;
        end
    end

endmodule

// File: rtl/window_mac.sv
// rtl/window_mac.sv - iterative k*k window dot product with bias, rounding, saturation and raster index
module window_mac
    import cnn_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [WEIGHT_SIZE-1:0][DATA_WIDTH-1:0] win,
    input  logic                                  w_wr_en,
    input  logic [ADDRESS_NUM-1:0]                w_addr,
    input  logic [DATA_WIDTH-1:0]                 w_data,
    input  logic                                  relu_en,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_WIDTH-1:0]                 out_data,
    output logic [IDX_WIDTH-1:0]                  out_idx,
    output logic                                  out_last,
    output logic                                  w_drop
);

    localparam int TAP_W = $clog2(WEIGHT_SIZE);
    localparam logic [TAP_W-1:0]     LAST_BASE = TAP_W'(WEIGHT_SIZE - LANES);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(FMAP_SIZE - 1);

    state_t                                 state;
    logic [WEIGHT_SIZE-1:0][DATA_WIDTH-1:0] weights;
    logic [WEIGHT_SIZE-1:0][DATA_WIDTH-1:0] win_q;
    logic signed [DATA_WIDTH-1:0]           bias;
    logic                                   relu_q;
    logic [TAP_W-1:0]                       tap_base;
    logic signed [ACC_WIDTH-1:0]            acc;
    logic signed [ACC_WIDTH-1:0]            lane_sum;
    logic signed [2*DATA_WIDTH-1:0]         prod [LANES];
    logic signed [DATA_WIDTH-1:0]           post_data;
    logic [IDX_WIDTH-1:0]                   next_idx;

    // Each lane picks tap tap_base+l from the latched window and the weight file.
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            prod[l]  = $signed(win_q[tap_base + TAP_W'(l)]) * $signed(weights[tap_base + TAP_W'(l)]);
            lane_sum = lane_sum + ACC_WIDTH'(prod[l]);
        end
    end

    assign next_idx = (out_idx == LAST_IDX) ? '0 : out_idx + 1'b1;

    win_postproc u_postproc (
        .acc     (acc),
        .bias    (bias),
        .relu_en (relu_q),
        .result  (post_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            w_drop    <= 1'b0;
            weights   <= '0;
            bias      <= '0;
            win_q     <= '0;
            relu_q    <= 1'b0;
            acc       <= '0;
            tap_base  <= '0;
        end else begin
            if (w_wr_en && state != IDLE) begin
                w_drop <= 1'b1;
            end
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (w_wr_en) begin
                        if (w_addr < ADDRESS_NUM'(WEIGHT_SIZE)) begin
                            weights[w_addr] <= w_data;
                        end else if (w_addr == ADDRESS_NUM'(WEIGHT_SIZE)) begin
                            bias <= w_data;
                        end
                    end
                    if (start) begin
                        out_idx  <= '0;
                        out_last <= 1'b0;
                    end
                    if (in_valid && in_ready) begin
                        win_q    <= win;
                        relu_q   <= relu_en;
                        acc      <= '0;
                        tap_base <= '0;
                        in_ready <= 1'b0;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + lane_sum;
                    if (tap_base == LAST_BASE) begin
                        state <= POST;
                    end else begin
                        tap_base <= tap_base + TAP_W'(LANES);
                    end
                end
                POST: begin
                    out_data  <= post_data;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_idx   <= next_idx;
                        out_last  <= (next_idx == LAST_IDX);
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_window_mac.sv
// tb/tb_window_mac.sv - scoreboard bench for window_mac
module tb_window_mac;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [24:0][15:0] win = '0;
    logic              w_wr_en = 1'b0;
    logic [4:0]        w_addr = '0;
    logic [15:0]       w_data = '0;
    logic              relu_en = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [15:0]       out_data;
    logic [9:0]        out_idx;
    logic              out_last;
    logic              w_drop;

    window_mac dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .win       (win),
        .w_wr_en   (w_wr_en),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .relu_en   (relu_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .w_drop    (w_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [9:0]  idx;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   cmp = 0;
    int   bad = 0;
    int   mw[25];
    int   mbias = 0;
    int   mwin[25];
    int   exp_idx = 0;

    function automatic logic [15:0] model(input bit relu);
        longint s = 0;
        for (int i = 0; i < 25; i++) s += longint'(mw[i]) * longint'(mwin[i]);
        s = s + longint'(mbias) * 256 + 128;
        s = s >>> 8;
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return s[15:0];
    endfunction

    task automatic write_reg(input int addr, input int data);
        w_wr_en = 1'b1;
        w_addr  = 5'(addr);
        w_data  = 16'(data);
        @(negedge clk);
        w_wr_en = 1'b0;
        if (addr < 25) mw[addr] = data;
        else if (addr == 25) mbias = data;
    endtask

    task automatic fill_weights(input int wv, input int bv);
        for (int i = 0; i < 25; i++) write_reg(i, wv);
        write_reg(25, bv);
    endtask

    task automatic set_win(input int v);
        for (int i = 0; i < 25; i++) mwin[i] = v;
    endtask

    task automatic send(input bit relu, input bit st);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        cmp++;
        if (!in_ready) begin
            bad++;
            $display("FAIL send_ready: in_ready=%0b required 1 within 50 cycles", in_ready);
            return;
        end
        for (int i = 0; i < 25; i++) win[i] = 16'(mwin[i]);
        relu_en  = relu;
        start    = st;
        in_valid = 1'b1;
        if (st) exp_idx = 0;
        sb.push_back(exp_t'{model(relu), 10'(exp_idx), 1'(exp_idx == 575)});
        exp_idx = (exp_idx + 1) % 576;
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic take(output exp_t e, output bit ok, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        ok = out_valid;
        if (sb.size() > 0) e = sb.pop_front();
        else e = exp_t'{16'h0, 10'h0, 1'b0};
        cmp++;
        if (!ok) begin
            bad++;
            $display("FAIL take_timeout: out_valid=%0b required 1 within 40 cycles", out_valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        cmp++;
        if ({in_ready, out_valid, out_data, out_idx, out_last, w_drop} !== 30'h0) begin
            bad++;
            $display("FAIL reset_state: rdy=%0b vld=%0b data=%0h idx=%0d last=%0b drop=%0b required all 0",
                     in_ready, out_valid, out_data, out_idx, out_last, w_drop);
        end
        rst = 1'b0;
        @(negedge clk);
        cmp++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: in_ready=%0b required 1", in_ready);
        end
        for (int i = 0; i < 25; i++) mw[i] = 0;
        mbias = 0;
    endtask

    task automatic test_basic();
        exp_t e; bit ok; int lat;
        fill_weights(256, 0);
        set_win(256);
        send(1'b0, 1'b0);
        take(e, ok, lat);
        cmp++;
        if (lat !== 6) begin
            bad++;
            $display("FAIL basic_latency: got %0d clocks required 6", lat);
        end
        cmp++;
        if (out_data !== 16'd6400 || out_idx !== 10'd0 || out_data !== e.data) begin
            bad++;
            $display("FAIL basic_result: data=%0d idx=%0d required data=6400 idx=0", $signed(out_data), out_idx);
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        exp_t e; bit ok; int lat;
        fill_weights(32767, 32767);
        set_win(32767);
        send(1'b0, 1'b0);
        take(e, ok, lat);
        cmp++;
        if (out_data !== 16'h7fff || out_data !== e.data || out_idx !== e.idx) begin
            bad++;
            $display("FAIL sat_pos: data=%0d idx=%0d required data=32767 idx=%0d", $signed(out_data), out_idx, e.idx);
        end
        @(negedge clk);
        fill_weights(-32768, 32767);
        send(1'b0, 1'b0);
        take(e, ok, lat);
        cmp++;
        if (out_data !== 16'h8000 || out_data !== e.data || out_idx !== e.idx) begin
            bad++;
            $display("FAIL sat_neg: data=%0d idx=%0d required data=-32768 idx=%0d", $signed(out_data), out_idx, e.idx);
        end
        @(negedge clk);
    endtask

    task automatic test_relu();
        exp_t e; bit ok; int lat;
        for (int i = 0; i < 24; i++) write_reg(i, -256);
        write_reg(25, 0);
        set_win(256);
        // Last tap written on the same edge that accepts the window.
        mw[24]  = -256;
        w_wr_en = 1'b1;
        w_addr  = 5'd24;
        w_data  = 16'hff00;
        send(1'b0, 1'b0);
        w_wr_en = 1'b0;
        take(e, ok, lat);
        cmp++;
        if (out_data !== 16'hE700 || out_data !== e.data || out_idx !== e.idx) begin
            bad++;
            $display("FAIL relu_off: data=%0d idx=%0d required data=-6400 idx=%0d", $signed(out_data), out_idx, e.idx);
        end
        @(negedge clk);
        send(1'b1, 1'b0);
        take(e, ok, lat);
        cmp++;
        if (out_data !== 16'h0 || out_data !== e.data || out_idx !== e.idx) begin
            bad++;
            $display("FAIL relu_on: data=%0d idx=%0d required data=0 idx=%0d", $signed(out_data), out_idx, e.idx);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        exp_t e; bit ok; int lat;
        for (int i = 0; i < 25; i++) mwin[i] = (i + 1) * 64;
        out_ready = 1'b0;
        send(1'b0, 1'b0);
        take(e, ok, lat);
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            for (int i = 0; i < 25; i++) win[i] = 16'h1234;
            cmp++;
            if (out_valid !== 1'b1 || out_data !== e.data || out_idx !== e.idx || out_last !== e.last || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_cycle%0d: vld=%0b data=%0d idx=%0d rdy=%0b required vld=1 data=%0d idx=%0d rdy=0",
                         c, out_valid, $signed(out_data), out_idx, in_ready, $signed(e.data), e.idx);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_release: rdy=%0b vld=%0b required rdy=1 vld=0", in_ready, out_valid);
        end
        repeat (8) @(negedge clk);
        cmp++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_ignored: out_valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_stream();
        exp_t e; bit ok; int lat;
        for (int i = 0; i < 25; i++) write_reg(i, int'($urandom_range(1023)) - 512);
        write_reg(25, int'($urandom_range(2047)) - 1024);
        for (int n = 0; n < 577; n++) begin
            for (int i = 0; i < 25; i++) mwin[i] = int'($urandom_range(2047)) - 1024;
            send(1'($urandom_range(1)), n == 0);
            take(e, ok, lat);
            cmp++;
            if (out_data !== e.data || out_idx !== e.idx || out_last !== e.last) begin
                bad++;
                $display("FAIL stream_%0d: data=%0d idx=%0d last=%0b required data=%0d idx=%0d last=%0b",
                         n, $signed(out_data), out_idx, out_last, $signed(e.data), e.idx, e.last);
            end
            if (n == 575 || n == 576) begin
                cmp++;
                if (out_last !== (n == 575) || out_idx !== ((n == 575) ? 10'd575 : 10'd0)) begin
                    bad++;
                    $display("FAIL stream_edge_%0d: idx=%0d last=%0b", n, out_idx, out_last);
                end
            end
            @(negedge clk);
        end
        for (int n = 0; n < 5; n++) begin
            if (n == 2) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                exp_idx = 0;
            end
            send(1'b0, n == 4);
            take(e, ok, lat);
            cmp++;
            if (out_data !== e.data || out_idx !== e.idx || out_last !== e.last) begin
                bad++;
                $display("FAIL start_%0d: data=%0d idx=%0d required data=%0d idx=%0d",
                         n, $signed(out_data), out_idx, $signed(e.data), e.idx);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_drop_and_reset();
        exp_t e; bit ok; int lat;
        fill_weights(256, 0);
        set_win(256);
        send(1'b0, 1'b0);
        w_wr_en = 1'b1;
        w_addr  = 5'd0;
        w_data  = 16'd1000;
        @(negedge clk);
        w_wr_en = 1'b0;
        cmp++;
        if (w_drop !== 1'b1) begin
            bad++;
            $display("FAIL drop_flag: w_drop=%0b required 1", w_drop);
        end
        take(e, ok, lat);
        cmp++;
        if (out_data !== 16'd6400 || out_data !== e.data) begin
            bad++;
            $display("FAIL drop_weight: data=%0d required 6400", $signed(out_data));
        end
        @(negedge clk);
        send(1'b0, 1'b0);
        void'(sb.pop_front());
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || w_drop !== 1'b0 || out_idx !== 10'd0) begin
            bad++;
            $display("FAIL midrst_state: vld=%0b rdy=%0b drop=%0b idx=%0d required 0 0 0 0",
                     out_valid, in_ready, w_drop, out_idx);
        end
        rst = 1'b0;
        @(negedge clk);
        cmp++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_ready: in_ready=%0b required 1", in_ready);
        end
        for (int i = 0; i < 25; i++) mw[i] = 0;
        mbias   = 0;
        exp_idx = 0;
        send(1'b0, 1'b0);
        take(e, ok, lat);
        cmp++;
        if (out_data !== 16'h0 || out_idx !== 10'd0 || lat !== 6 || out_data !== e.data) begin
            bad++;
            $display("FAIL midrst_cleared: data=%0d idx=%0d lat=%0d required data=0 idx=0 lat=6",
                     $signed(out_data), out_idx, lat);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_relu();
        test_backpressure();
        test_stream();
        test_drop_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
